alu_response_checker: RTL and testbench
=======================================

ALU_RESPONSE_CHECKER -- requirements
Module: alu_response_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, 1, cycles operands are held on the ALU before sampling (legal range 0..15).
REQ-002 Parameter: CNT_W, 16, width of pass/fail/index counters.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: vec_valid  in  1  test vector present on vec_data.
REQ-006 Port: vec_ready  out  1  checker accepts a vector this cycle.
REQ-007 Port: vec_data  in  102  {ALUControl[1:0], a[31:0], b[31:0], exp_result[31:0], exp_flags[3:0]}, MSB first.
REQ-008 Port: vec_last  in  1  qualifies vec_data as final vector of the run.
REQ-009 Port: alu_a, alu_b  out  32 each  operands driven to the ALU.
REQ-010 Port: alu_control  out  2  ALUControl to the ALU (00 add, 01 sub, 10 and, 11 or).
REQ-011 Port: alu_result  in  32  ALU Result.
REQ-012 Port: alu_flags  in  4  ALUFlags {N,Z,C,V}.
REQ-013 Port: pass_count, fail_count  out  CNT_W each  checked-vector tallies.
REQ-014 Port: first_fail_idx  out  CNT_W  index (0-based) of first failing vector.
REQ-015 Port: any_fail  out  1  sticky, set on first mismatch.
REQ-016 Port: done  out  1  run complete.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-018 IDLE: vec_ready=1; on vec_valid&vec_ready, latch vec_data and vec_last into registers; go SETTLE (CHECK directly if SETTLE_CYCLES=0).
REQ-019 alu_a/alu_b/alu_control SHALL be driven only from latched registers, stable from acceptance edge until next acceptance.
REQ-020 SETTLE: down-counter loaded with SETTLE_CYCLES at acceptance; decrement each cycle; go CHECK when it expires (exactly SETTLE_CYCLES cycles in SETTLE).
REQ-021 CHECK: one cycle; compare alu_result (and alu_flags per REQ-031) against latched expectations; vec_ready=0.
REQ-022 At edge ending CHECK: match -> pass_count+1; mismatch -> fail_count+1, any_fail=1, and if any_fail was 0, first_fail_idx=vector index; vector index +1.
REQ-023 From CHECK: latched vec_last=1 -> DONE, else IDLE.
REQ-024 Counters updated at edge A+SETTLE_CYCLES+1 where A is acceptance edge; throughput one vector per SETTLE_CYCLES+2 cycles.
REQ-025 vec_ready SHALL be 1 only in IDLE; vec_valid outside IDLE SHALL be ignored and not lost (sender holds).
REQ-026 DONE: done=1, vec_ready=0, all outputs frozen until reset.
REQ-027 pass_count, fail_count, vector index SHALL saturate at all-ones (no wrap).

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE; alu_a=alu_b=0; alu_control=00; all counters, first_fail_idx, any_fail, done=0.
REQ-029 Reset in any state (including SETTLE/CHECK) SHALL abort the in-flight vector with no counter update; reset has priority over handshake.
REQ-030 vec_ready SHALL be 0 during a reset cycle, 1 in first cycle after reset deasserts.

Configuration
REQ-031 Macro ALU_CHECK_FLAGS_EN: defined -> match requires alu_result==exp_result AND alu_flags==exp_flags; undefined -> only alu_result compared, exp_flags ignored.

Verification
REQ-032 SETTLE_CYCLES=1; vector ctl=10, a=FF0F_FFFF, b=FFFF_FFFF, exp=FF0F_FFFF, flags=1000, last=1 -> alu outputs match, pass_count=1 at acceptance+2 edges, done=1 next cycle.
REQ-033 Two vectors: OR F0F0_F0F0|0F0F_0F0F exp FFFF_FFFF flags 1000, then ADD 7FFF_FFFF+1 exp 8000_0000 flags 1001 -> pass_count=2, fail_count=0, vectors accepted 3 cycles apart.
REQ-034 Vectors 0..2 with vector 1 exp_result wrong (0000_0001 for AND) -> fail_count=1, first_fail_idx=1, any_fail=1, pass_count=2.
REQ-035 Result correct, exp_flags wrong -> fail_count=1 with ALU_CHECK_FLAGS_EN defined; pass_count=1 without.
REQ-036 Reset asserted during SETTLE of vector 0 -> counters 0, alu outputs 0, vec_ready=1 one cycle after release; vec_valid held during non-IDLE never double-counted.
REQ-037 SETTLE_CYCLES=0 and 15 -> CHECK at acceptance+1 and +16 edges respectively.

Source files
------------

// File: rtl/alu_response_checker.sv
// ----------------------------------------------------------------------------
// alu_response_checker
//
// Applies test vectors to an external 32-bit ALU and checks its responses.
// Each accepted vector drives its operands and control onto the ALU. The
// checker waits SETTLE_CYCLES cycles for the ALU to settle. It then samples
// the ALU output once and updates the pass/fail tallies. A vector that
// carries vec_last ends the run, and done stays set until reset.
//
// Build option:
//   ALU_CHECK_FLAGS_EN  defined   -> a vector passes only if both the result
//                                    and the flags {N,Z,C,V} match
//                       undefined -> only the result is compared; the
//                                    expected flags are ignored
//
// Parameters:
//   SETTLE_CYCLES  cycles operands are held before sampling (0..15)
//   CNT_W          width of pass/fail/index counters
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   vec_valid/ready   vector handshake; ready only while idle
//   vec_data[101:0]   {ALUControl[1:0], a, b, exp_result, exp_flags[3:0]}
//   vec_last          marks the final vector of the run
//   alu_a/b/control   operands driven to the ALU (from latched registers)
//   alu_result/flags  ALU response {N,Z,C,V}
//   pass_count        vectors that matched (saturating)
//   fail_count        vectors that mismatched (saturating)
//   first_fail_idx    0-based index of the first failing vector
//   any_fail          sticky mismatch flag
//   done              run complete; all outputs frozen until reset
// ----------------------------------------------------------------------------
module alu_response_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [101:0]     vec_data,
    input  logic             vec_last,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [1:0]       alu_control,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             any_fail,
    output logic             done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state;
    logic [3:0]       settle_cnt;
    logic [31:0]      exp_result;
    logic             lat_last;
    logic [CNT_W-1:0] vec_idx;
    logic             match;

`ifdef ALU_CHECK_FLAGS_EN
    logic [3:0]       exp_flags;

    assign match = (alu_result == exp_result) && (alu_flags == exp_flags);
`else
    // The flag inputs still exist on the port list; fold them into one
    // deliberately unused bit so nothing dangles silently.
    logic             unused_flags;

    assign unused_flags = ^{alu_flags, vec_data[3:0]};
    assign match        = (alu_result == exp_result);
`endif

    // NOTE: ready is gated by reset combinationally. This keeps the
    // handshake low for the whole reset cycle, so reset wins over a
    // vector offered at the same edge.
    assign vec_ready = (state == IDLE) && !reset;

    // NOTE: every register here is state. Non-blocking assignments let
    // all of them see the values from before the edge, so no update
    // depends on the order in which the statements are written.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_control    <= '0;
            exp_result     <= '0;
`ifdef ALU_CHECK_FLAGS_EN
            exp_flags      <= '0;
`endif
            lat_last       <= 1'b0;
            vec_idx        <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            any_fail       <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vec_valid && vec_ready) begin
                        alu_control <= vec_data[101:100];
                        alu_a       <= vec_data[99:68];
                        alu_b       <= vec_data[67:36];
                        exp_result  <= vec_data[35:4];
`ifdef ALU_CHECK_FLAGS_EN
                        exp_flags   <= vec_data[3:0];
`endif
                        lat_last    <= vec_last;
                        settle_cnt  <= SETTLE_LOAD;
                        state       <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                    end
                end

                SETTLE: begin
                    // The count is loaded with SETTLE_CYCLES. Leaving when it
                    // reads 1 gives exactly SETTLE_CYCLES cycles in this state.
                    if (settle_cnt <= 4'd1) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                CHECK: begin
                    if (match) begin
                        if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_ONE;
                    end else begin
                        if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_ONE;
                        if (!any_fail) first_fail_idx <= vec_idx;
                        any_fail <= 1'b1;
                    end
                    if (vec_idx != CNT_MAX) vec_idx <= vec_idx + CNT_ONE;
                    done  <= lat_last;
                    state <= lat_last ? DONE : IDLE;
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// ----------------------------------------------------------------------------
// tb_alu_response_checker
//
// Self-checking bench for alu_response_checker.
//
// A behavioural ALU answers the DUT's operand outputs. A transaction-level
// model predicts the DUT outputs on every cycle: which vectors are accepted,
// when each verdict lands, the tallies and the latched operands. One compare
// process checks the DUT against the model on every falling edge. Directed
// scenarios pin the model with literal values.
//
// Two extra instances cover the remaining cases. The first uses
// SETTLE_CYCLES=0 with 2-bit counters to exercise zero-settle timing and
// saturation. The second uses SETTLE_CYCLES=15 to exercise long-settle
// timing.
// ----------------------------------------------------------------------------
module tb_alu_response_checker;

    localparam int MAIN_S = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         vec_valid = 1'b0;
    logic         vec_ready;
    logic [101:0] vec_data = '0;
    logic         vec_last = 1'b0;
    logic [31:0]  alu_a, alu_b, alu_result;
    logic [1:0]   alu_control;
    logic [3:0]   alu_flags;
    logic [15:0]  pass_count, fail_count, first_fail_idx;
    logic         any_fail, done;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural ALU: {result, N, Z, C, V}
    // ------------------------------------------------------------------
    function automatic logic [35:0] alu_fn(input logic [1:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (ctl)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    function automatic bit verdict(input logic [101:0] d);
        logic [35:0] rf;
        rf = alu_fn(d[101:100], d[99:68], d[67:36]);
`ifdef ALU_CHECK_FLAGS_EN
        return (rf[35:4] == d[35:4]) && (rf[3:0] == d[3:0]);
`else
        return (rf[35:4] == d[35:4]);
`endif
    endfunction

    function automatic logic [101:0] mkvec(input logic [1:0] ctl, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] e,
                                           input logic [3:0] f);
        return {ctl, a, b, e, f};
    endfunction

    assign {alu_result, alu_flags} = alu_fn(alu_control, alu_a, alu_b);

    alu_response_checker #(.SETTLE_CYCLES(MAIN_S), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_data(vec_data), .vec_last(vec_last), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .alu_result(alu_result), .alu_flags(alu_flags),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .any_fail(any_fail), .done(done)
    );

    // ------------------------------------------------------------------
    // Auxiliary instances: SETTLE_CYCLES=0 (2-bit counters) and 15
    // ------------------------------------------------------------------
    logic         valid0 = 1'b0, valid15 = 1'b0;
    logic [101:0] aux_data = '0;
    logic         ready0, ready15, any0, any15, done0, done15;
    logic [31:0]  a0, b0, r0, a15, b15, r15;
    logic [1:0]   c0, c15;
    logic [3:0]   f0, f15;
    logic [1:0]   pc0, fc0, ffi0;
    logic [15:0]  pc15, fc15, ffi15;

    assign {r0, f0}   = alu_fn(c0, a0, b0);
    assign {r15, f15} = alu_fn(c15, a15, b15);

    alu_response_checker #(.SETTLE_CYCLES(0), .CNT_W(2)) u_s0 (
        .clk(clk), .reset(reset), .vec_valid(valid0), .vec_ready(ready0),
        .vec_data(aux_data), .vec_last(1'b0), .alu_a(a0), .alu_b(b0),
        .alu_control(c0), .alu_result(r0), .alu_flags(f0),
        .pass_count(pc0), .fail_count(fc0), .first_fail_idx(ffi0),
        .any_fail(any0), .done(done0)
    );

    alu_response_checker #(.SETTLE_CYCLES(15), .CNT_W(16)) u_s15 (
        .clk(clk), .reset(reset), .vec_valid(valid15), .vec_ready(ready15),
        .vec_data(aux_data), .vec_last(1'b0), .alu_a(a15), .alu_b(b15),
        .alu_control(c15), .alu_result(r15), .alu_flags(f15),
        .pass_count(pc15), .fail_count(fc15), .first_fail_idx(ffi15),
        .any_fail(any15), .done(done15)
    );

    // ------------------------------------------------------------------
    // Transaction-level model of the main instance
    // ------------------------------------------------------------------
    bit          m_init = 0, m_busy = 0, m_done = 0, m_last = 0, m_verdict = 0, m_any = 0;
    int          m_left = 0;
    logic [15:0] m_pass = '0, m_fail = '0, m_ffi = '0, m_idx = '0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [1:0]  m_ctl = '0;
    wire         m_ready = !reset && !m_busy && !m_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init <= 1; m_busy <= 0; m_done <= 0; m_last <= 0; m_any <= 0;
            m_pass <= '0; m_fail <= '0; m_ffi <= '0; m_idx <= '0;
            m_a <= '0; m_b <= '0; m_ctl <= '0; m_left <= 0;
        end else if (m_init) begin
            if (m_busy) begin
                if (m_left == 1) begin
                    // Verdict lands SETTLE_CYCLES+1 edges after acceptance.
                    if (m_verdict) m_pass <= sat_inc(m_pass);
                    else begin
                        m_fail <= sat_inc(m_fail);
                        if (!m_any) m_ffi <= m_idx;
                        m_any <= 1;
                    end
                    m_idx  <= sat_inc(m_idx);
                    m_busy <= 0;
                    m_done <= m_last;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (!m_done && vec_valid) begin
                m_ctl     <= vec_data[101:100];
                m_a       <= vec_data[99:68];
                m_b       <= vec_data[67:36];
                m_verdict <= verdict(vec_data);
                m_last    <= vec_last;
                m_left    <= MAIN_S + 1;
                m_busy    <= 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            check("vec_ready", 64'(vec_ready), 64'(m_ready));
            check("pass_count", 64'(pass_count), 64'(m_pass));
            check("fail_count", 64'(fail_count), 64'(m_fail));
            check("first_fail_idx", 64'(first_fail_idx), 64'(m_ffi));
            check("any_fail", 64'(any_fail), 64'(m_any));
            check("done", 64'(done), 64'(m_done));
            check("alu_a", 64'(alu_a), 64'(m_a));
            check("alu_b", 64'(alu_b), 64'(m_b));
            check("alu_control", 64'(alu_control), 64'(m_ctl));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic reset_dut();
        vec_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [101:0] d, input logic last, output int acc);
        bit ok;
        ok = 0; acc = -1;
        vec_data = d; vec_last = last; vec_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (vec_ready) begin
                @(posedge clk); #1;
                acc = cyc; ok = 1;
            end
        end
        vec_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_s0(input logic [101:0] d);
        bit ok;
        ok = 0;
        aux_data = d; valid0 = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (ready0) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        valid0 = 1'b0;
        if (!ok) check("s0_accept_timeout", 64'd0, 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        int acc1, acc2, t0, t15;
        int exp_pass, exp_fail, exp_ffi;
        logic [101:0] d;
        logic [35:0]  rf;
        logic [1:0]   ctl;
        logic [31:0]  a, b, e;
        logic [3:0]   f;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(vec_ready), 64'd1);
        check("reset_pass", 64'(pass_count), 64'd0);
        check("reset_alu_a", 64'(alu_a), 64'd0);
        @(posedge clk); #1;

        // AND with last: pass, done, then frozen against further vectors.
        send(mkvec(2'b10, 32'hFF0F_FFFF, 32'hFFFF_FFFF, 32'hFF0F_FFFF, 4'b1000), 1'b1, acc1);
        @(posedge clk); #1;
        check("and_pass_early", 64'(pass_count), 64'd0);
        @(posedge clk); #1;
        check("and_pass", 64'(pass_count), 64'd1);
        check("and_done", 64'(done), 64'd1);
        check("and_alu_a", 64'(alu_a), 64'hFF0F_FFFF);
        vec_data = mkvec(2'b00, 32'd1, 32'd1, 32'd2, 4'b0000); vec_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 vec_valid = 1'b0;
        check("done_frozen_pass", 64'(pass_count), 64'd1);
        check("done_frozen_ready", 64'(vec_ready), 64'd0);

        // OR then ADD overflow, back to back.
        reset_dut();
        send(mkvec(2'b11, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b1000), 1'b0, acc1);
        send(mkvec(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001), 1'b1, acc2);
        wait_done();
        check("b2b_spacing", 64'(acc2 - acc1), 64'd3);
        check("b2b_pass", 64'(pass_count), 64'd2);
        check("b2b_fail", 64'(fail_count), 64'd0);

        // Vector 1 carries a wrong expected result.
        reset_dut();
        send(mkvec(2'b00, 32'd5, 32'd6, 32'd11, 4'b0000), 1'b0, acc1);
        send(mkvec(2'b10, 32'hF0, 32'h0F, 32'h1, 4'b0100), 1'b0, acc1);
        send(mkvec(2'b01, 32'd9, 32'd4, 32'd5, 4'b0010), 1'b1, acc1);
        wait_done();
        check("bad1_fail", 64'(fail_count), 64'd1);
        check("bad1_ffi", 64'(first_fail_idx), 64'd1);
        check("bad1_any", 64'(any_fail), 64'd1);
        check("bad1_pass", 64'(pass_count), 64'd2);

        // Correct result, wrong flags (5-3 really gives C=1).
        reset_dut();
        send(mkvec(2'b01, 32'd5, 32'd3, 32'd2, 4'b0000), 1'b1, acc1);
        wait_done();
`ifdef ALU_CHECK_FLAGS_EN
        check("flags_fail", 64'(fail_count), 64'd1);
`else
        check("flags_pass", 64'(pass_count), 64'd1);
`endif

        // Reset during SETTLE with the vector held valid throughout.
        reset_dut();
        vec_data = mkvec(2'b00, 32'd10, 32'd20, 32'd30, 4'b0000);
        vec_last = 1'b0; vec_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(vec_ready), 64'd1);
        check("abort_pass", 64'(pass_count), 64'd0);
        check("abort_alu_a", 64'(alu_a), 64'd0);
        @(posedge clk); #1;
        vec_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_single_count", 64'(pass_count), 64'd1);

        // Randomised run.
        reset_dut();
        exp_pass = 0; exp_fail = 0; exp_ffi = -1;
        for (int i = 0; i < 40; i++) begin
            ctl = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            rf = alu_fn(ctl, a, b);
            e = rf[35:4]; f = rf[3:0];
            if ($urandom_range(0, 3) == 0) e = e ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) f = f ^ 4'(($urandom_range(1, 15)));
            d = mkvec(ctl, a, b, e, f);
            if (verdict(d)) exp_pass++;
            else begin
                if (exp_ffi < 0) exp_ffi = i;
                exp_fail++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(d, (i == 39), acc1);
        end
        wait_done();
        check("rand_pass", 64'(pass_count), 64'(exp_pass));
        check("rand_fail", 64'(fail_count), 64'(exp_fail));
        if (exp_ffi >= 0) check("rand_ffi", 64'(first_fail_idx), 64'(exp_ffi));

        // Settle extremes: verdict edge is acceptance+1 and acceptance+16.
        aux_data = mkvec(2'b00, 32'd1, 32'd2, 32'd3, 4'b0000);
        valid0 = 1'b1; valid15 = 1'b1;
        @(negedge clk);
        check("aux_ready0", 64'(ready0), 64'd1);
        check("aux_ready15", 64'(ready15), 64'd1);
        @(posedge clk); #1;
        valid0 = 1'b0; valid15 = 1'b0;
        t0 = 0; t15 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (pc0 != 0 && t0 == 0) t0 = k;
            if (pc15 != 0 && t15 == 0) t15 = k;
        end
        check("settle0_edge", 64'(t0), 64'd1);
        check("settle15_edge", 64'(t15), 64'd16);

        // Saturation of 2-bit counters.
        for (int i = 0; i < 5; i++) send_s0(mkvec(2'b00, 32'd1, 32'd2, 32'd3, 4'b0000));
        send_s0(mkvec(2'b00, 32'd1, 32'd2, 32'd4, 4'b0000));
        repeat (3) @(posedge clk);
        #1;
        check("sat_pass", 64'(pc0), 64'd3);
        check("sat_fail", 64'(fc0), 64'd1);
        check("sat_ffi", 64'(ffi0), 64'd3);
        check("sat_any", 64'(any0), 64'd1);
        check("s15_pass", 64'(pc15), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
